// File: rtl/tick_pwm.sv
// Tick-driven PWM with double-buffered period/duty applied at period wrap.
// Define TICK_PWM_ONESHOT_EN to add the oneshot input, done output and DONE state.
module tick_pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tick,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    input  logic             load,
`ifdef TICK_PWM_ONESHOT_EN
    input  logic             oneshot,
    output logic             done,
`endif
    output logic             load_ack,
    output logic             pwm_out,
    output logic [WIDTH-1:0] cnt,
    output logic             period_end
);

`ifdef TICK_PWM_ONESHOT_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] period_act, duty_act;
    logic [WIDTH-1:0] sh_period, sh_duty;
    logic             pending;

    logic [WIDTH-1:0] cnt_n, per_n, dut_n;
    logic             pwm_n, pe_n, ack_n, done_n;
    logic             step, wrap, apply, upd, zero_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pwm_n   = pwm_out;
        pe_n    = 1'b0;
        ack_n   = 1'b0;
        done_n  = 1'b0;
        per_n   = period_act;
        dut_n   = duty_act;
        apply   = 1'b0;
        upd     = 1'b0;
        step    = en && tick;
        wrap    = step && (cnt == period_act);

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                apply = pending;
            end
            RUN: begin
                if (step) begin
                    upd = 1'b1;
                    if (wrap) begin
                        cnt_n = '0;
                        pe_n  = 1'b1;
                        apply = pending;
                    end else begin
                        cnt_n = cnt + WIDTH'(1);
                    end
                end
            end
`ifdef TICK_PWM_ONESHOT_EN
            DONE: begin
                cnt_n = '0;
                apply = pending;
            end
`endif
            default: state_n = IDLE;
        endcase

        // Apply always takes the pre-edge shadow contents.
        if (apply) begin
            per_n = sh_period;
            dut_n = sh_duty;
            ack_n = 1'b1;
            upd   = 1'b1;
        end

        zero_n = (per_n == '0) && (dut_n == '0);
        if (apply) begin
            state_n = zero_n ? IDLE : RUN;
        end

`ifdef TICK_PWM_ONESHOT_EN
        if (state == RUN && wrap && oneshot && !zero_n) begin
            state_n = DONE;
            done_n  = 1'b1;
        end
`endif

        if (state_n == RUN) begin
            pwm_n = upd ? (cnt_n < dut_n) : pwm_out;
        end else begin
            pwm_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
            load_ack   <= 1'b0;
            period_act <= '0;
            duty_act   <= '0;
            sh_period  <= '0;
            sh_duty    <= '0;
            pending    <= 1'b0;
`ifdef TICK_PWM_ONESHOT_EN
            done       <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pwm_out    <= pwm_n;
            period_end <= pe_n;
            load_ack   <= ack_n;
            period_act <= per_n;
            duty_act   <= dut_n;
            pending    <= load | (pending & ~apply);
            if (load) begin
                sh_period <= period;
                sh_duty   <= duty;
            end
`ifdef TICK_PWM_ONESHOT_EN
            done       <= done_n;
`endif
        end
    end

`ifndef TICK_PWM_ONESHOT_EN
    logic unused_done;
    assign unused_done = done_n;
`endif

endmodule

// File: tb/tb_tick_pwm.sv
// Directed bench for tick_pwm with hand-computed cnt/pwm/period_end/load_ack.
// Oneshot scenario is compiled only when TICK_PWM_ONESHOT_EN is defined.
module tb_tick_pwm;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, en, tick, load;
    logic [W-1:0] period, duty;
    logic         load_ack, pwm_out, period_end;
    logic [W-1:0] cnt;
`ifdef TICK_PWM_ONESHOT_EN
    logic         oneshot, done;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_pwm #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .tick       (tick),
        .period     (period),
        .duty       (duty),
        .load       (load),
`ifdef TICK_PWM_ONESHOT_EN
        .oneshot    (oneshot),
        .done       (done),
`endif
        .load_ack   (load_ack),
        .pwm_out    (pwm_out),
        .cnt        (cnt),
        .period_end (period_end)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic ck(input string tag, input int c, input int p,
                      input int pe, input int ack);
        chk({tag, ".cnt"}, int'(cnt), c);
        chk({tag, ".pwm"}, int'(pwm_out), p);
        chk({tag, ".pe"}, int'(period_end), pe);
        chk({tag, ".ack"}, int'(load_ack), ack);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ldv(input int p, input int d);
        load   = 1'b1;
        period = W'(p);
        duty   = W'(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int ec, hi, np, pe_e;
        reset = 1'b1; en = 1'b0; tick = 1'b0; load = 1'b0;
        period = '0; duty = '0;
`ifdef TICK_PWM_ONESHOT_EN
        oneshot = 1'b0;
`endif
        cyc();
        cyc();
        ck("rst", 0, 0, 0, 0);
`ifdef TICK_PWM_ONESHOT_EN
        chk("rst.done", int'(done), 0);
`endif

        // 4/2, tick every clock: 1,1,0,0,0 repeating
        reset = 1'b0; en = 1'b1; tick = 1'b1;
        ldv(4, 2);
        cyc();
        load = 1'b0;
        ck("cap", 0, 0, 0, 0);
        cyc();
        ck("apply", 0, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            int c;
            c = (i + 1) % 5;
            cyc();
            ck("p42", c, int'(c < 2), int'(c == 0), 0);
        end

        // 3/1, tick every third clock
        do_reset();
        tick = 1'b0;
        ldv(3, 1);
        cyc();
        load = 1'b0;
        cyc();
        ck("t3apply", 0, 1, 0, 1);
        ec = 0; hi = 0; np = 0;
        for (int j = 0; j < 24; j++) begin
            tick = (j % 3 == 2);
            pe_e = 0;
            if (tick) begin
                if (ec == 3) begin
                    ec = 0;
                    pe_e = 1;
                end else begin
                    ec++;
                end
            end
            cyc();
            ck("t3", ec, int'(ec < 1), pe_e, 0);
            hi += int'(pwm_out);
            np += int'(period_end);
        end
        chk("t3hi", hi, 6);
        chk("t3pe", np, 2);

        // mid-period reload 7/6 while running 4/2
        do_reset();
        tick = 1'b1;
        ldv(4, 2);
        cyc();
        load = 1'b0;
        cyc();
        ck("mp.apply", 0, 1, 0, 1);
        cyc(); ck("mp1", 1, 1, 0, 0);
        cyc(); ck("mp2", 2, 0, 0, 0);
        ldv(7, 6);
        cyc();
        load = 1'b0;
        ck("mp3", 3, 0, 0, 0);
        cyc(); ck("mp4", 4, 0, 0, 0);
        cyc(); ck("mpwrap", 0, 1, 1, 1);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            ck("mp76", c, int'(c < 6), 0, 0);
        end
        cyc(); ck("mp76wrap", 0, 1, 1, 0);

        // duty 0, then duty 9 > period, then 0/0 back to IDLE
        do_reset();
        ldv(4, 0);
        cyc();
        load = 1'b0;
        cyc(); ck("d0.apply", 0, 0, 0, 1);
        for (int c = 1; c <= 4; c++) begin
            cyc(); ck("d0", c, 0, 0, 0);
        end
        ldv(4, 9);
        cyc();
        load = 1'b0;
        ck("d0wrap", 0, 0, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            cyc(); ck("d0b", c, 0, 0, 0);
        end
        cyc(); ck("d9.apply", 0, 1, 1, 1);
        for (int c = 1; c <= 4; c++) begin
            cyc(); ck("d9", c, 1, 0, 0);
        end
        ldv(0, 0);
        cyc();
        load = 1'b0;
        ck("d9wrap", 0, 1, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            cyc(); ck("d9b", c, 1, 0, 0);
        end
        cyc(); ck("z.apply", 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); ck("idle", 0, 0, 0, 0);
        end

        // load and apply on the same edge
        do_reset();
        ldv(1, 1);
        cyc();
        ldv(2, 0);
        cyc();
        load = 1'b0;
        ck("sim.apply", 0, 1, 0, 1);
        cyc(); ck("sim1", 1, 0, 0, 0);
        cyc(); ck("sim.wrap", 0, 0, 1, 1);
        cyc(); ck("sim2a", 1, 0, 0, 0);
        cyc(); ck("sim2b", 2, 0, 0, 0);
        cyc(); ck("sim2w", 0, 0, 1, 0);

        // en low freezes counting, then reset drops a pending load
        do_reset();
        ldv(4, 2);
        cyc();
        load = 1'b0;
        cyc();
        cyc(); ck("en1", 1, 1, 0, 0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); ck("en0", 1, 1, 0, 0);
        end
        en = 1'b1;
        cyc(); ck("en2", 2, 0, 0, 0);
        cyc(); ck("en3", 3, 0, 0, 0);
        ldv(2, 1);
        cyc();
        load = 1'b0;
        ck("en4", 4, 0, 0, 0);
        reset = 1'b1;
        cyc();
        ck("mrst", 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); ck("post", 0, 0, 0, 0);
        end

`ifdef TICK_PWM_ONESHOT_EN
        do_reset();
        oneshot = 1'b1;
        ldv(2, 1);
        cyc();
        load = 1'b0;
        cyc(); ck("os.apply", 0, 1, 0, 1);
        chk("os.done0", int'(done), 0);
        cyc(); ck("os1", 1, 0, 0, 0);
        cyc(); ck("os2", 2, 0, 0, 0);
        cyc(); ck("os.wrap", 0, 0, 1, 0);
        chk("os.done1", int'(done), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); ck("os.hold", 0, 0, 0, 0);
            chk("os.doneh", int'(done), 0);
        end
        ldv(2, 1);
        cyc();
        load = 1'b0;
        ck("os.cap", 0, 0, 0, 0);
        cyc(); ck("os.rerun", 0, 1, 0, 1);
        chk("os.done2", int'(done), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
